shift_arbiter: RTL and testbench

- Shares one combinational N-bit barrel shifter between two requesters: port 0 is the EX-stage ALU shift path, port 1 is the load/store byte-alignment path.
- Arbitrates between the ports and applies each accepted operation to the shifter.
- Registers the result and returns it to the owning requester over a valid/ready handshake.
- Sits in the execute stage beside the ALU.

---
 rtl/shift_arbiter_pkg.sv | 17 +
 rtl/shift_arbiter_if.sv | 26 ++
 rtl/shift_arbiter_shifter.sv | 21 ++
 rtl/shift_arbiter.sv | 109 ++++++++++
 tb/tb_shift_arbiter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for shift_arbiter: shift-type encodings and the
// IDLE/HOLD state encoding of the result register.
package shift_arbiter_pkg;

    localparam logic [1:0] SHIFT_SRL  = 2'b00;
    localparam logic [1:0] SHIFT_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_PASS = 2'b11;

    localparam int SHAMT_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// One requester port of shift_arbiter: request handshake plus the
// registered response handshake. master = requester, slave = arbiter.
interface shift_arbiter_if
    import shift_arbiter_pkg::*;
#(
    parameter int N = 32
);
    logic               valid;
    logic               ready;
    logic [N-1:0]       a;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op_type;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [N-1:0]       rsp_r;

    modport master (
        output valid, a, shamt, op_type, rsp_ready,
        input  ready, rsp_valid, rsp_r
    );

    modport slave (
        input  valid, a, shamt, op_type, rsp_ready,
        output ready, rsp_valid, rsp_r
    );
endinterface

// File: rtl/shift_arbiter_shifter.sv
// Combinational N-bit barrel shifter (SRL/SLL/SRA). Code 11 is not decoded
// here and falls through to SRL; the caller muxes pass-through around it.
module shift_arbiter_shifter
    import shift_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]       a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic [N-1:0]       r_o
);
    always_comb begin
        r_o = a_i >> shamt_i;
        case (op_i)
            SHIFT_SLL: r_o = a_i << shamt_i;
            SHIFT_SRA: r_o = $signed(a_i) >>> shamt_i;
            default:   ;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one barrel shifter, with a registered result
// returned over valid/ready. Define SHIFT_ARB_RR_EN for round-robin ties;
// otherwise port 0 always wins a tie.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave p0,
    shift_arbiter_if.slave p1
);
    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [N-1:0]       result_q, result_d;

    logic               prio;
    logic               owner_rsp_ready;
    logic               accept_ok;
    logic               grant0, grant1;
    logic [N-1:0]       sel_a;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [1:0]         sel_type;
    logic [N-1:0]       shift_r;
    logic [N-1:0]       op_r;

`ifdef SHIFT_ARB_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant0) begin
            ptr_d = 1'b1;
        end else if (grant1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign prio = ptr_q;
`else
    assign prio = 1'b0;
`endif

    // A full register can be refilled in the same cycle its owner drains it.
    assign owner_rsp_ready = owner_q ? p1.rsp_ready : p0.rsp_ready;
    assign accept_ok       = !rst && ((state_q == ST_IDLE) || owner_rsp_ready);

    assign grant0 = accept_ok && p0.valid && (!p1.valid || !prio);
    assign grant1 = accept_ok && p1.valid && (!p0.valid ||  prio);

    assign p0.ready = grant0;
    assign p1.ready = grant1;

    assign sel_a     = grant1 ? p1.a       : p0.a;
    assign sel_shamt = grant1 ? p1.shamt   : p0.shamt;
    assign sel_type  = grant1 ? p1.op_type : p0.op_type;

    shift_arbiter_shifter #(
        .N (N)
    ) u_shifter (
        .a_i     (sel_a),
        .shamt_i (sel_shamt),
        .op_i    (sel_type),
        .r_o     (shift_r)
    );

    assign op_r = (sel_type == SHIFT_PASS) ? sel_a : shift_r;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        if (grant0 || grant1) begin
            state_d  = ST_HOLD;
            owner_d  = grant1;
            result_d = op_r;
        end else if ((state_q == ST_HOLD) && owner_rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
        end
    end

    // Outputs are forced low while rst is asserted, even before the state clears.
    assign p0.rsp_valid = !rst && (state_q == ST_HOLD) && !owner_q;
    assign p1.rsp_valid = !rst && (state_q == ST_HOLD) &&  owner_q;
    assign p0.rsp_r     = p0.rsp_valid ? result_q : '0;
    assign p1.rsp_r     = p1.rsp_valid ? result_q : '0;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_shift_arbiter;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    shift_arbiter_if #(.N(N)) p0_if ();
    shift_arbiter_if #(.N(N)) p1_if ();

    shift_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .p0  (p0_if),
        .p1  (p1_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is a result outstanding, whose is it, what is it, who wins a tie.
    bit          m_full   = 1'b0;
    int          m_owner  = 0;
    logic [31:0] m_result = '0;
    int          m_prio   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference shifter from arithmetic: multiply/divide by powers of two.
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                              input logic [1:0] t);
        longint p;
        longint x;
        longint q;
        p = longint'(1) << s;
        x = longint'(a);
        case (t)
            2'b00: q = x / p;
            2'b01: q = (x * p) % 64'sh1_0000_0000;
            2'b10: begin
                if (a[31]) x = x - 64'sh1_0000_0000;
                if (x >= 0) q = x / p;
                else        q = -((-x + p - 1) / p);
            end
            default: q = x;
        endcase
        return q[31:0];
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge.
    task automatic step(input logic rst_v,
                        input logic v0, input logic [31:0] a0, input logic [4:0] s0,
                        input logic [1:0] t0, input logic rr0,
                        input logic v1, input logic [31:0] a1, input logic [4:0] s1,
                        input logic [1:0] t1, input logic rr1);
        logic        e_rdy0, e_rdy1, e_rv0, e_rv1;
        logic [31:0] e_r0, e_r1;
        int          g;
        bit          own_rdy;
        rst = rst_v;
        p0_if.valid = v0; p0_if.a = a0; p0_if.shamt = s0; p0_if.op_type = t0; p0_if.rsp_ready = rr0;
        p1_if.valid = v1; p1_if.a = a1; p1_if.shamt = s1; p1_if.op_type = t1; p1_if.rsp_ready = rr1;
        #1;
        g = -1;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_r0 = '0; e_r1 = '0;
        if (!rst_v) begin
            e_rv0 = m_full && (m_owner == 0);
            e_rv1 = m_full && (m_owner == 1);
            e_r0  = e_rv0 ? m_result : 32'h0;
            e_r1  = e_rv1 ? m_result : 32'h0;
            own_rdy = (m_owner == 1) ? rr1 : rr0;
            if (!m_full || own_rdy) begin
                if (v0 && v1) g = m_prio;
                else if (v0)  g = 0;
                else if (v1)  g = 1;
            end
        end
        e_rdy0 = (g == 0);
        e_rdy1 = (g == 1);
        chk("p0_ready",     {31'b0, p0_if.ready},     {31'b0, e_rdy0});
        chk("p1_ready",     {31'b0, p1_if.ready},     {31'b0, e_rdy1});
        chk("p0_rsp_valid", {31'b0, p0_if.rsp_valid}, {31'b0, e_rv0});
        chk("p1_rsp_valid", {31'b0, p1_if.rsp_valid}, {31'b0, e_rv1});
        chk("p0_rsp_r",     p0_if.rsp_r,              e_r0);
        chk("p1_rsp_r",     p1_if.rsp_r,              e_r1);
        @(posedge clk);
        if (rst_v) begin
            m_full = 1'b0; m_owner = 0; m_result = '0; m_prio = 0;
        end else if (g >= 0) begin
            m_full   = 1'b1;
            m_owner  = g;
            m_result = (g == 0) ? ref_shift(a0, s0, t0) : ref_shift(a1, s1, t1);
`ifdef SHIFT_ARB_RR_EN
            m_prio   = 1 - g;
`endif
            $display("txn port=%0d a=%h shamt=%0d type=%0d result=%h", g,
                     (g == 0) ? a0 : a1, (g == 0) ? s0 : s1, (g == 0) ? t0 : t1, m_result);
        end else if (m_full && (((m_owner == 1) ? rr1 : rr0) == 1'b1)) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input logic rr0, input logic rr1);
        step(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, rr0, 1'b0, 32'h0, 5'd0, 2'b00, rr1);
    endtask

    logic [31:0] exp_b2b [4];
    logic [31:0] held;

    initial begin
        exp_b2b[0] = 32'h20; exp_b2b[1] = 32'h40; exp_b2b[2] = 32'h80; exp_b2b[3] = 32'h100;
        p0_if.valid = 1'b0; p0_if.a = '0; p0_if.shamt = '0; p0_if.op_type = '0; p0_if.rsp_ready = 1'b0;
        p1_if.valid = 1'b0; p1_if.a = '0; p1_if.shamt = '0; p1_if.op_type = '0; p1_if.rsp_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset, with requests present: nothing may be granted.
        repeat (2) step(1'b1, 1'b1, 32'h1, 5'd1, 2'b01, 1'b1, 1'b1, 32'h1, 5'd1, 2'b01, 1'b1);
        idle(1'b0, 1'b0);

        // 1: SRA sign fill.
        step(1'b0, 1'b1, 32'h8000_0000, 5'd4, 2'b10, 1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
        chk("t1_p0_rsp_r", p0_if.rsp_r, 32'hF800_0000);
        chk("t1_p1_rsp_valid", {31'b0, p1_if.rsp_valid}, 32'h0);
        idle(1'b1, 1'b0);

        // 2: simultaneous requests.
        step(1'b0, 1'b1, 32'h1, 5'd31, 2'b01, 1'b1, 1'b1, 32'h8000_0000, 5'd31, 2'b00, 1'b1);
        chk("t2_p0_first", p0_if.rsp_r, 32'h8000_0000);
        step(1'b0, 1'b1, 32'h1, 5'd31, 2'b01, 1'b1, 1'b1, 32'h8000_0000, 5'd31, 2'b00, 1'b1);
`ifdef SHIFT_ARB_RR_EN
        chk("t2_p1_second", p1_if.rsp_r, 32'h0000_0001);
`else
        repeat (3) step(1'b0, 1'b1, 32'h1, 5'd31, 2'b01, 1'b1, 1'b1, 32'h8000_0000, 5'd31, 2'b00, 1'b1);
        chk("t2_p1_starved", {31'b0, p1_if.rsp_valid}, 32'h0);
`endif
        idle(1'b1, 1'b1);

        // 3: pass-through ignores shamt; shamt 0 is identity.
        step(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd7, 2'b11, 1'b0);
        chk("t3_pass", p1_if.rsp_r, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h7FFF_FFFF, 5'd0, 2'b10, 1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1);
        chk("t3_sra0", p0_if.rsp_r, 32'h7FFF_FFFF);
        idle(1'b1, 1'b0);

        // 4: backpressure holds the result; releasing it grants p1 at once.
        step(1'b0, 1'b1, 32'h0000_00F0, 5'd3, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
        held = p0_if.rsp_r;
        chk("t4_first", held, 32'h0000_001E);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 32'h0000_0003, 5'd2, 2'b01, 1'b1);
            chk("t4_stable", p0_if.rsp_r, held);
        end
        step(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b1, 32'h0000_0003, 5'd2, 2'b01, 1'b0);
        chk("t4_p1_result", p1_if.rsp_r, 32'h0000_000C);
        idle(1'b0, 1'b1);

        // 5: back-to-back throughput.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h10, 5'(i + 1), 2'b01, 1'b1, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
            chk("t5_b2b", p0_if.rsp_r, exp_b2b[i]);
        end
        idle(1'b1, 1'b0);

        // 6: reset during HOLD discards the result and clears the pointer.
        step(1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 32'h1234_5678, 5'd4, 2'b00, 1'b0);
        step(1'b1, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 2'b00, 1'b0);
        chk("t6_rv0", {31'b0, p0_if.rsp_valid}, 32'h0);
        chk("t6_rv1", {31'b0, p1_if.rsp_valid}, 32'h0);
        chk("t6_r1",  p1_if.rsp_r, 32'h0);
        step(1'b0, 1'b1, 32'h5, 5'd1, 2'b01, 1'b1, 1'b1, 32'h5, 5'd1, 2'b00, 1'b1);
        chk("t6_ptr0", p0_if.rsp_r, 32'hA);
        idle(1'b1, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra0, ra1;
            ra0 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), ra0, 5'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom), ra1, 5'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
